systolic_result_drain: RTL and testbench
========================================

// Module: systolic_result_drain
//
// PURPOSE
// Consumer end of the systolic_array result interface (z_o / z_valid_o / z_yumi_i).
// - Waits until every MAC accumulator reports valid.
// - Captures the full result matrix, releases the array with a one-cycle yumi.
// - Serialises the results row-major onto a single valid/ready stream for a host or DMA.
//
// PARAMETERS
// width_p         32  accumulator / output word width (two's complement)
// array_width_p    2  result columns (W)
// array_height_p   2  result rows (H)
//
// PORTS
// clk_i         in   1        clock, all state on rising edge
// reset_i       in   1        synchronous reset, active-high
// z_i           in   width_p*W*H  flat result bus from the array; element [r][c] in slot s=r+c*H
// z_valid_i     in   W*H      per-slot valid, slot indexing as z_i
// z_yumi_o      out  W*H      per-slot consume strobe to the array
// data_o        out  width_p  serialised result word
// data_valid_o  out  1        data_o valid
// data_ready_i  in   1        downstream accepts data_o when high with data_valid_o
// row_o         out  $clog2(H) (min 1)  row index of data_o
// col_o         out  $clog2(W) (min 1)  column index of data_o
// last_o        out  1        data_o is element [H-1][W-1]
// busy_o        out  1        high whenever state != IDLE
//
// BEHAVIOUR
// - Reset: state=IDLE; row/col counters 0. z_yumi_o, data_valid_o, last_o, busy_o = 0.
//   data_o, row_o and col_o are 0. The capture buffer is not reset.
// - States: IDLE, SEND.
// - IDLE, yumi:
//   - z_yumi_o = {W*H{&z_valid_i}} (combinational).
//   - All slots are yumi'd together in that one cycle, or none are.
//   - Partial valid: no yumi and no capture; stay in IDLE.
// - IDLE, capture: on an edge where &z_valid_i, latch all W*H words and go to SEND with r=c=0.
// - SEND, output:
//   - data_valid_o=1; data_o = buffer[r][c]; row_o=r, col_o=c.
//   - last_o = (r==H-1 && c==W-1).
// - SEND, advance:
//   - Handshake = data_valid_o & data_ready_i.
//   - On handshake: c++; at c==W-1, wrap c=0 and r++.
//   - On handshake with last_o: go to IDLE and clear the counters.
// - Backpressure: while data_ready_i=0, data_o, row_o, col_o and last_o hold stable.
// - SEND: z_yumi_o=0. New z_valid_i is ignored (never consumed) until back in IDLE.
// - Latency and throughput:
//   - First word is valid on the cycle after the yumi cycle.
//   - With ready held high, W*H words arrive on consecutive cycles.
//   - Minimum one IDLE cycle between frames, so frame period >= W*H+1 cycles.
// - Arithmetic: words pass through unchanged (no sign change, no truncation). Counters never exceed H-1 / W-1.
// - Reset mid-SEND: the frame is abandoned; next cycle is IDLE with all outputs at their reset values.
//   Consumed results are lost; not re-requested.
// - Reset while z_valid_i all high: z_yumi_o is 0 during reset (gated by reset_i).
//
// TESTING
// 1. 2x2, ready=1: slots [0][0]=-2103, [0][1]=-3707, [1][0]=21950, [1][1]=30, all valid.
//    -> z_yumi_o=4'b1111 for exactly 1 cycle.
//    -> Next 4 cycles data_o = FFFFF7C9, FFFFF185, 000055BE, 0000001E with (row,col) = 00, 01, 10, 11.
//    -> last_o high only on the 4th word; then busy_o=0.
// 2. Partial valid z_valid_i=4'b0111 for 10 cycles -> z_yumi_o=0, data_valid_o=0, busy_o=0.
//    Then raise to 4'b1111 -> yumi in that same cycle.
// 3. Backpressure: frame of 1 above; data_ready_i=0 for 3 cycles on word 2.
//    -> data_o holds FFFFF185, row/col=01.
//    -> Frame completes in 4+3 cycles in order; no word dropped or duplicated.
// 4. New frame during SEND: z_valid_i held all-ones throughout.
//    -> Second yumi only in the IDLE cycle after last_o handshake.
//    -> Second frame's words follow; period = 5 cycles.
// 5. Reset mid-SEND after word 2 -> next cycle IDLE, data_valid_o=0, row/col=0.
//    -> Following frame starts cleanly at [0][0].
// 6. Parameter sweep W=H=3, values 1..9 -> output order 1..9, last_o on 9, 9 consecutive words with ready=1.

Source files
------------

// File: rtl/systolic_result_drain.sv
// systolic_result_drain
// Consumer end of a systolic array result interface. Waits until every MAC
// slot reports valid, captures the whole result matrix while releasing the
// array with a single-cycle yumi, then streams the words row-major over a
// valid/ready interface.
//
// Ports
//   clk_i, reset_i   clock, synchronous active-high reset
//   z_i              flat result bus, element [r][c] in slot s = r + c*H
//   z_valid_i        per-slot valid, same slot order as z_i
//   z_yumi_o         per-slot consume strobe (combinational, all-or-none)
//   data_o           serialised result word
//   data_valid_o     data_o valid
//   data_ready_i     downstream accept
//   row_o, col_o     matrix coordinates of data_o
//   last_o           data_o is element [H-1][W-1]
//   busy_o           a frame is being streamed
module systolic_result_drain #(
  parameter int unsigned width_p        = 32,
  parameter int unsigned array_width_p  = 2,
  parameter int unsigned array_height_p = 2
) (
  input  logic                                              clk_i,
  input  logic                                              reset_i,
  input  logic [width_p*array_width_p*array_height_p-1:0]   z_i,
  input  logic [array_width_p*array_height_p-1:0]           z_valid_i,
  output logic [array_width_p*array_height_p-1:0]           z_yumi_o,
  output logic [width_p-1:0]                                data_o,
  output logic                                              data_valid_o,
  input  logic                                              data_ready_i,
  output logic [((array_height_p > 1) ? $clog2(array_height_p) : 1)-1:0] row_o,
  output logic [((array_width_p > 1) ? $clog2(array_width_p) : 1)-1:0]   col_o,
  output logic                                              last_o,
  output logic                                              busy_o
);

  localparam int unsigned W  = array_width_p;
  localparam int unsigned H  = array_height_p;
  localparam int unsigned N  = W * H;
  localparam int unsigned RW = (H > 1) ? $clog2(H) : 1;
  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
  localparam int unsigned SW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [RW-1:0]       row_q, row_d;
  logic [CW-1:0]       col_q, col_d;
  logic [width_p-1:0]  data_q, data_d;
  logic                last_q, last_d;
  logic [width_p-1:0]  res_q [N];
  logic                all_valid_c;
  logic                capture_c;

  // Slot index of element [r][c] in the column-major capture buffer.
  function automatic logic [SW-1:0] slot_f(input logic [RW-1:0] r, input logic [CW-1:0] c);
    return SW'(r) + SW'(c) * SW'(H);
  endfunction

  assign all_valid_c = &z_valid_i;
  assign capture_c   = (state_q == IDLE) && all_valid_c && !reset_i;

  // Whole-matrix release: every slot or none, never while streaming.
  assign z_yumi_o = capture_c ? {N{1'b1}} : '0;

  // State, counters and output word registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  // Capture buffer; contents only matter while streaming, so no reset.
  always_ff @(posedge clk_i) begin
    if (capture_c) begin
      for (int unsigned s = 0; s < N; s++) begin
        res_q[s] <= z_i[s*width_p +: width_p];
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    data_d  = data_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (capture_c) begin
          state_d = SEND;
          row_d   = '0;
          col_d   = '0;
          // Buffer is loading on this edge, so take word [0][0] from the bus.
          data_d  = z_i[width_p-1:0];
          last_d  = (N == 1);
        end
      end
      SEND: begin
        if (data_ready_i) begin
          if (last_q) begin
            state_d = IDLE;
            row_d   = '0;
            col_d   = '0;
            data_d  = '0;
            last_d  = 1'b0;
          end else begin
            if (col_q == CW'(W - 1)) begin
              col_d = '0;
              row_d = row_q + RW'(1);
            end else begin
              col_d = col_q + CW'(1);
            end
            data_d = res_q[slot_f(row_d, col_d)];
            last_d = (row_d == RW'(H - 1)) && (col_d == CW'(W - 1));
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign data_o       = data_q;
  assign row_o        = row_q;
  assign col_o        = col_q;
  assign last_o       = last_q;
  assign data_valid_o = (state_q == SEND);
  assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_systolic_result_drain.sv
// Directed bench for systolic_result_drain: a 2x2 instance for the main
// scenarios and a 3x3 instance for the larger-array ordering check.
module tb_systolic_result_drain;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 2x2 instance
  logic [127:0] za;
  logic [3:0]   zva, yumia;
  logic [31:0]  da;
  logic         dva, rdya, lasta, busya;
  logic [0:0]   rowa, cola;

  // 3x3 instance
  logic [287:0] zb;
  logic [8:0]   zvb, yumib;
  logic [31:0]  db;
  logic         dvb, rdyb, lastb, busyb;
  logic [1:0]   rowb, colb;

  systolic_result_drain #(.width_p(32), .array_width_p(2), .array_height_p(2)) u_a (
    .clk_i(clk), .reset_i(rst), .z_i(za), .z_valid_i(zva), .z_yumi_o(yumia),
    .data_o(da), .data_valid_o(dva), .data_ready_i(rdya), .row_o(rowa),
    .col_o(cola), .last_o(lasta), .busy_o(busya)
  );

  systolic_result_drain #(.width_p(32), .array_width_p(3), .array_height_p(3)) u_b (
    .clk_i(clk), .reset_i(rst), .z_i(zb), .z_valid_i(zvb), .z_yumi_o(yumib),
    .data_o(db), .data_valid_o(dvb), .data_ready_i(rdyb), .row_o(rowb),
    .col_o(colb), .last_o(lastb), .busy_o(busyb)
  );

  int n_chk = 0;
  int n_bad = 0;
  logic [31:0] ew [4];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance to just after the next falling edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Check the 2x2 instance is presenting word k of the reference frame.
  task automatic chk_word_a(input string tag, input int k);
    chk({tag, ".valid"}, 32'(dva), 32'd1);
    chk({tag, ".data"},  da, ew[k]);
    chk({tag, ".row"},   32'(rowa), 32'(k / 2));
    chk({tag, ".col"},   32'(cola), 32'(k % 2));
    chk({tag, ".last"},  32'(lasta), 32'(k == 3));
    chk({tag, ".yumi"},  32'(yumia), 32'd0);
  endtask

  task automatic chk_idle_a(input string tag);
    chk({tag, ".valid"}, 32'(dva), 32'd0);
    chk({tag, ".busy"},  32'(busya), 32'd0);
    chk({tag, ".last"},  32'(lasta), 32'd0);
  endtask

  initial begin
    // Reference frame: [0][0]=-2103 [0][1]=-3707 [1][0]=21950 [1][1]=30, slot = r + 2c.
    ew[0] = 32'hFFFFF7C9;
    ew[1] = 32'hFFFFF185;
    ew[2] = 32'h000055BE;
    ew[3] = 32'h0000001E;
    za  = {32'h0000001E, 32'hFFFFF185, 32'h000055BE, 32'hFFFFF7C9};
    zb  = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        zb[(r + c*3)*32 +: 32] = 32'(r*3 + c + 1);
    zvb  = '0;
    rdya = 1'b1;
    rdyb = 1'b1;

    // Reset with all slots valid: yumi must stay low.
    rst = 1'b1;
    zva = 4'hF;
    tick();
    tick();
    chk("rst.yumi", 32'(yumia), 32'd0);
    chk("rst.data", da, 32'd0);
    chk("rst.row",  32'(rowa), 32'd0);
    chk("rst.col",  32'(cola), 32'd0);
    chk_idle_a("rst");

    // Test 1: basic frame with ready held high.
    rst = 1'b0;
    #1;
    chk("t1.yumi", 32'(yumia), 32'hF);
    chk("t1.busy0", 32'(busya), 32'd0);
    tick();
    zva = 4'h0;
    for (int k = 0; k < 4; k++) begin
      chk_word_a($sformatf("t1.w%0d", k), k);
      tick();
    end
    chk_idle_a("t1.end");
    chk("t1.end.yumi", 32'(yumia), 32'd0);

    // Test 2: partial valid never releases the array.
    zva = 4'b0111;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t2.yumi", 32'(yumia), 32'd0);
      chk_idle_a("t2");
    end
    zva = 4'hF;
    #1;
    chk("t2.yumi_full", 32'(yumia), 32'hF);

    // Test 3: backpressure on word 1 for three cycles.
    tick();
    zva = 4'h0;
    chk_word_a("t3.w0", 0);
    tick();
    rdya = 1'b0;
    chk_word_a("t3.w1a", 1);
    tick();
    chk_word_a("t3.w1b", 1);
    tick();
    chk_word_a("t3.w1c", 1);
    tick();
    chk_word_a("t3.w1d", 1);
    rdya = 1'b1;
    tick();
    chk_word_a("t3.w2", 2);
    tick();
    chk_word_a("t3.w3", 3);
    tick();
    chk_idle_a("t3.end");

    // Test 4: valid held high, back-to-back frames with period 5.
    zva = 4'hF;
    #1;
    chk("t4.yumi1", 32'(yumia), 32'hF);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_word_a($sformatf("t4.f1w%0d", k), k);
    end
    tick();
    chk("t4.yumi2", 32'(yumia), 32'hF);
    chk_idle_a("t4.gap");
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_word_a($sformatf("t4.f2w%0d", k), k);
    end
    zva = 4'h0;
    tick();
    chk_idle_a("t4.end");

    // Test 5: reset while word 2 is presented abandons the frame.
    zva = 4'hF;
    #1;
    chk("t5.yumi", 32'(yumia), 32'hF);
    tick();
    zva = 4'h0;
    chk_word_a("t5.w0", 0);
    tick();
    chk_word_a("t5.w1", 1);
    tick();
    chk_word_a("t5.w2", 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle_a("t5.rst");
    chk("t5.rst.row", 32'(rowa), 32'd0);
    chk("t5.rst.col", 32'(cola), 32'd0);
    zva = 4'hF;
    #1;
    chk("t5.yumi2", 32'(yumia), 32'hF);
    tick();
    zva = 4'h0;
    for (int k = 0; k < 4; k++) begin
      chk_word_a($sformatf("t5.f2w%0d", k), k);
      tick();
    end
    chk_idle_a("t5.end");

    // Test 6: 3x3 array, row-major order 1..9 on consecutive cycles.
    zvb = '1;
    #1;
    chk("t6.yumi", 32'(yumib), 32'h1FF);
    tick();
    zvb = '0;
    for (int k = 0; k < 9; k++) begin
      chk("t6.valid", 32'(dvb), 32'd1);
      chk($sformatf("t6.data%0d", k), db, 32'(k + 1));
      chk("t6.row",  32'(rowb), 32'(k / 3));
      chk("t6.col",  32'(colb), 32'(k % 3));
      chk("t6.last", 32'(lastb), 32'(k == 8));
      tick();
    end
    chk("t6.end.busy",  32'(busyb), 32'd0);
    chk("t6.end.valid", 32'(dvb), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
